// File: rtl/crc_pkg.sv
// ----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the multi-lane serial CRC engine used on the SD
// CMD line (CRC7) and the DAT lines (CRC16).
//   CRC7_POLY   generator for the CMD line, x^7 term omitted
//   CRC16_POLY  generator for the DAT lines, x^16 term omitted
//   state_t     framing FSM encoding: IDLE, ACCUM, TAIL
//   MODE_*      tail behaviour latched with istart
// ----------------------------------------------------------------------------
package crc_pkg;

  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

endpackage

// File: rtl/crc_lane.sv
// ----------------------------------------------------------------------------
// crc_lane
// One serial MSB-first CRC LFSR. During payload accumulation each enabled bit
// is folded into the register through the generator polynomial; during the
// tail phase the register is shifted with no feedback so its contents walk
// out of the MSB one bit per enable.
// Ports:
//   iclk   in  1  clock, rising edge
//   irst   in  1  synchronous reset, active-high
//   iclr   in  1  synchronous clear, wins over ien
//   ien    in  1  advance the LFSR this cycle
//   itail  in  1  1 = plain shift (tail), 0 = CRC feedback shift
//   idata  in  1  serial payload bit
//   ocrc   out 1  current CRC MSB
// ----------------------------------------------------------------------------
module crc_lane
  import crc_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_POLY)
) (
  input  logic iclk,
  input  logic irst,
  input  logic iclr,
  input  logic ien,
  input  logic itail,
  input  logic idata,
  output logic ocrc
);

  logic [WIDTH-1:0] r_crc;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;
  logic             w_fb;

  // Next LFSR value: feedback shift while accumulating, plain shift in the tail
  always_comb begin
    w_fb    = idata ^ r_crc[WIDTH-1];
    w_shift = {r_crc[WIDTH-2:0], 1'b0};
    w_next  = w_shift;
    if (itail) begin
      w_next = w_shift;
    end else if (w_fb) begin
      w_next = w_shift ^ POLY;
    end else begin
      w_next = w_shift;
    end
  end

  // LFSR register; holds whenever the bit-enable is low so stalls are harmless
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_crc <= {WIDTH{1'b0}};
    end else if (iclr) begin
      r_crc <= {WIDTH{1'b0}};
    end else if (ien) begin
      r_crc <= w_next;
    end else begin
      r_crc <= r_crc;
    end
  end

  assign ocrc = r_crc[WIDTH-1];

endmodule

// File: rtl/crc_lanes.sv
// ----------------------------------------------------------------------------
// crc_lanes
// Multi-lane serial CRC engine sitting between the bit (de)serialiser and the
// command/data FSMs. Each lane owns an independent LFSR. A framing FSM runs
// IDLE -> ACCUM (payload) -> TAIL (WIDTH counted bits) -> IDLE. In generate
// mode the tail shifts the CRC out MSB-first on ocrc; in check mode the tail
// compares the received bits against the CRC and latches a sticky mismatch.
// Ports:
//   iclk        in   1      clock, rising edge
//   irst        in   1      synchronous reset, active-high
//   istart      in   1      clear all lanes/counters, enter ACCUM (top priority)
//   imode       in   1      sampled with istart: 0 generate, 1 check
//   ivalid      in   1      bit-enable for payload and tail
//   idata       in   LANES  one serial bit per lane
//   iend        in   1      current ivalid bit (if any) is the last payload bit
//   ocrc        out  LANES  per-lane CRC MSB
//   ocrc_valid  out  1      TAIL in generate mode
//   obusy       out  1      ACCUM or TAIL
//   odone       out  1      one-cycle pulse after the last tail bit
//   ocrc_ok     out  1      check result, held until istart or irst
// ----------------------------------------------------------------------------
module crc_lanes
  import crc_pkg::*;
#(
  parameter int               LANES = 4,
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC16_POLY)
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             istart,
  input  logic             imode,
  input  logic             ivalid,
  input  logic [LANES-1:0] idata,
  input  logic             iend,
  output logic [LANES-1:0] ocrc,
  output logic             ocrc_valid,
  output logic             obusy,
  output logic             odone,
  output logic             ocrc_ok
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_mode;
  logic            w_mode_nxt;
  logic            r_mismatch;
  logic            w_mismatch_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_ok;
  logic            w_ok_nxt;
  logic            r_busy;
  logic            r_crc_valid;

  logic [LANES-1:0] w_msb;
  logic             w_lane_en;
  logic             w_lane_tail;
  logic             w_bit_err;

  // Lanes only move while framed; istart reaches them as a clear that beats ien
  assign w_lane_en   = ivalid & ((r_state == ST_ACCUM) | (r_state == ST_TAIL));
  assign w_lane_tail = (r_state == ST_TAIL);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    crc_lane #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_lane (
      .iclk  (iclk),
      .irst  (irst),
      .iclr  (istart),
      .ien   (w_lane_en),
      .itail (w_lane_tail),
      .idata (idata[l]),
      .ocrc  (w_msb[l])
    );
  end

  // Any lane whose received tail bit differs from its CRC MSB
  assign w_bit_err = |(idata ^ w_msb);

  // Framing FSM, tail counter, mismatch and result next-state
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_mode_nxt     = r_mode;
    w_mismatch_nxt = r_mismatch;
    w_done_nxt     = 1'b0;
    w_ok_nxt       = r_ok;
    if (istart) begin
      w_state_nxt    = ST_ACCUM;
      w_count_nxt    = {CW{1'b0}};
      w_mode_nxt     = imode;
      w_mismatch_nxt = 1'b0;
      w_ok_nxt       = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_ACCUM: begin
          if (iend) begin
            w_state_nxt = ST_TAIL;
            w_count_nxt = {CW{1'b0}};
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_TAIL: begin
          if (ivalid) begin
            // Final bit's comparison must feed the result written this edge
            w_mismatch_nxt = r_mismatch | (r_mode & w_bit_err);
            if (r_count == LAST_CNT) begin
              w_state_nxt = ST_IDLE;
              w_count_nxt = {CW{1'b0}};
              w_done_nxt  = 1'b1;
              w_ok_nxt    = r_mode & ~w_mismatch_nxt;
            end else begin
              w_count_nxt = r_count + CW'(1);
            end
          end else begin
            w_state_nxt = ST_TAIL;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = {CW{1'b0}};
        end
      endcase
    end
  end

  // State and output registers; status flags are registered from next-state
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state     <= ST_IDLE;
      r_count     <= {CW{1'b0}};
      r_mode      <= MODE_GEN;
      r_mismatch  <= 1'b0;
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_busy      <= 1'b0;
      r_crc_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_mode      <= w_mode_nxt;
      r_mismatch  <= w_mismatch_nxt;
      r_done      <= w_done_nxt;
      r_ok        <= w_ok_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_crc_valid <= (w_state_nxt == ST_TAIL) & (w_mode_nxt == MODE_GEN);
    end
  end

  assign ocrc       = w_msb;
  assign ocrc_valid = r_crc_valid;
  assign obusy      = r_busy;
  assign odone      = r_done;
  assign ocrc_ok    = r_ok;

endmodule
